// File: rtl/wordline_encoder_seq_if.sv
// Handshake bundle between a requester and the wordline encoder sequencer.
// The requester drives the mask and accept strobe; the encoder drives the issued index.
interface wordline_encoder_seq_if;
    logic        load;
    logic [15:0] Wordline;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [3:0]  RegId;
    logic        last;
    logic        done;
    logic [4:0]  count;

    modport master (
        output load, Wordline, ready,
        input  busy, valid, RegId, last, done, count
    );

    modport slave (
        input  load, Wordline, ready,
        output busy, valid, RegId, last, done, count
    );
endinterface

// File: rtl/wordline_encoder_seq.sv
// Walks a captured multi-hot register mask, presenting one register index per accepted
// handshake in ascending order, then pulses done for one cycle.
module wordline_encoder_seq (
    input  logic                  clk,
    input  logic                  rst,
    wordline_encoder_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [4:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        valid_w;
    logic [3:0]  reg_id_w;
    logic        last_w;

    // Bit 0 has the highest priority.
    function automatic logic [3:0] lowest_set(input logic [15:0] mask);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic is_one_hot(input logic [15:0] mask);
        return (mask != 16'd0) && ((mask & (mask - 16'd1)) == 16'd0);
    endfunction

    // Presented outputs depend only on registered state, never on ready or load.
    assign valid_w  = (state_q == ISSUE);
    assign reg_id_w = valid_w ? lowest_set(pending_q) : 4'd0;
    assign last_w   = valid_w && is_one_hot(pending_q);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    pending_d = bus.Wordline;
                    count_d   = 5'd0;
                    busy_d    = 1'b1;
                    if (bus.Wordline == 16'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.ready) begin
                    pending_d = pending_q & ~(16'd1 << reg_id_w);
                    count_d   = count_q + 5'd1;
                    if (last_w) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 16'd0;
            count_q   <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.valid = valid_w;
    assign bus.RegId = reg_id_w;
    assign bus.last  = last_w;
endmodule

// File: tb/tb_wordline_encoder_seq.sv
// Directed and randomized checks of the wordline encoder against an abstract mask model.
module tb_wordline_encoder_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   started = 1'b0;

    wordline_encoder_seq_if bus ();

    wordline_encoder_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Abstract model: remaining mask, in-sequence flag, done flag, accepted count.
    logic [15:0] m_pend = 16'd0;
    bit          m_act  = 1'b0;
    bit          m_done = 1'b0;
    int          m_cnt  = 0;

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 16'd0; m_act = 1'b0; m_done = 1'b0; m_cnt = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_act) begin
            if (bus.ready) begin
                m_pend[lowest(m_pend)] = 1'b0;
                m_cnt++;
                if (m_pend == 16'd0) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (bus.load) begin
            m_pend = bus.Wordline;
            m_cnt  = 0;
            if (bus.Wordline == 16'd0) m_done = 1'b1;
            else m_act = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", 32'(bus.valid), 32'(m_act));
            chk("m_regid", 32'(bus.RegId), m_act ? 32'(lowest(m_pend)) : 32'd0);
            chk("m_last",  32'(bus.last),  32'(m_act && ($countones(m_pend) == 1)));
            chk("m_done",  32'(bus.done),  32'(m_done));
            chk("m_busy",  32'(bus.busy),  32'(m_act || m_done));
            chk("m_count", 32'(bus.count), 32'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [15:0] w);
        bus.load = 1'b1;
        bus.Wordline = w;
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy),  32'd0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_regid"}, 32'(bus.RegId), 32'd0);
        chk({tag, "_last"},  32'(bus.last),  32'd0);
        chk({tag, "_done"},  32'(bus.done),  32'd0);
    endtask

    initial begin
        bus.load = 1'b0;
        bus.Wordline = 16'd0;
        bus.ready = 1'b0;
        cyc();
        cyc();
        check_idle_zero("reset");
        chk("reset_count", 32'(bus.count), 32'd0);
        rst = 1'b0;
        started = 1'b1;

        // 0x0005 with ready held high
        bus.ready = 1'b1;
        start_load(16'h0005);
        chk("h5_id0", 32'(bus.RegId), 32'd0);
        chk("h5_last0", 32'(bus.last), 32'd0);
        chk("h5_valid0", 32'(bus.valid), 32'd1);
        cyc();
        chk("h5_id1", 32'(bus.RegId), 32'd2);
        chk("h5_last1", 32'(bus.last), 32'd1);
        cyc();
        chk("h5_done", 32'(bus.done), 32'd1);
        chk("h5_dvalid", 32'(bus.valid), 32'd0);
        chk("h5_count", 32'(bus.count), 32'd2);
        cyc();
        check_idle_zero("h5_idle");
        chk("h5_hold", 32'(bus.count), 32'd2);

        // 0x8000 with ready stalled
        bus.ready = 1'b0;
        start_load(16'h8000);
        for (int i = 0; i < 3; i++) begin
            chk("h8k_valid", 32'(bus.valid), 32'd1);
            chk("h8k_id", 32'(bus.RegId), 32'd15);
            chk("h8k_last", 32'(bus.last), 32'd1);
            chk("h8k_cnt", 32'(bus.count), 32'd0);
            if (i < 2) cyc();
        end
        bus.ready = 1'b1;
        cyc();
        chk("h8k_done", 32'(bus.done), 32'd1);
        chk("h8k_count", 32'(bus.count), 32'd1);
        cyc();

        // empty mask
        start_load(16'h0000);
        chk("h0_valid", 32'(bus.valid), 32'd0);
        chk("h0_done", 32'(bus.done), 32'd1);
        chk("h0_busy", 32'(bus.busy), 32'd1);
        chk("h0_count", 32'(bus.count), 32'd0);
        cyc();
        check_idle_zero("h0_idle");

        // full mask
        start_load(16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            chk("hf_id", 32'(bus.RegId), 32'(i));
            chk("hf_last", 32'(bus.last), 32'(i == 15));
            cyc();
        end
        chk("hf_done", 32'(bus.done), 32'd1);
        chk("hf_count", 32'(bus.count), 32'd16);
        cyc();

        // load during ISSUE ignored
        start_load(16'h00F0);
        bus.load = 1'b1;
        bus.Wordline = 16'h0001;
        for (int i = 4; i < 8; i++) begin
            chk("hf0_id", 32'(bus.RegId), 32'(i));
            if (i == 5) bus.load = 1'b0;
            cyc();
        end
        chk("hf0_done", 32'(bus.done), 32'd1);
        chk("hf0_count", 32'(bus.count), 32'd4);
        cyc();

        // async reset mid-sequence
        start_load(16'h0C00);
        chk("hc_id0", 32'(bus.RegId), 32'd10);
        cyc();
        chk("hc_id1", 32'(bus.RegId), 32'd11);
        rst = 1'b1;
        #1;
        check_idle_zero("hc_rst");
        chk("hc_rst_count", 32'(bus.count), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("hc_nodone", 32'(bus.done), 32'd0);
        start_load(16'h0002);
        chk("hc_id2", 32'(bus.RegId), 32'd1);
        cyc();
        chk("hc_done", 32'(bus.done), 32'd1);
        chk("hc_count", 32'(bus.count), 32'd1);
        cyc();

        // randomized traffic, model compares every cycle
        for (int n = 0; n < 1500; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            bus.load  = ($urandom_range(0, 9) < 3);
            bus.ready = ($urandom_range(0, 9) < 7);
            if (sel == 0) bus.Wordline = 16'h0000;
            else if (sel == 1) bus.Wordline = 16'hFFFF;
            else if (sel < 5) bus.Wordline = 16'(1) << $urandom_range(0, 15);
            else bus.Wordline = 16'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
                #1;
            end
            cyc();
        end
        bus.load = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wordline_encoder_seq.md
WORDLINE_ENCODER_SEQ -- requirements
Module: wordline_encoder_seq

Interface
REQ-001 Parameters: none; widths fixed at 16 wordlines / 4-bit RegId.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 load  input  1  capture request for Wordline; honoured only in IDLE.
REQ-005 Wordline  input  16  multi-hot register mask; bit i set = register i pending.
REQ-006 ready  input  1  downstream (register-file write port) accepts current RegId.
REQ-007 busy  output  1  high in ISSUE or DONE state.
REQ-008 valid  output  1  RegId is presented for acceptance.
REQ-009 RegId  output  4  encoded register index currently presented.
REQ-010 last  output  1  current RegId is the final pending register.
REQ-011 done  output  1  one-cycle pulse, sequence complete.
REQ-012 count  output  5  number of registers accepted in current/last sequence (0-16).

Function
REQ-013 Block SHALL hold a 16-bit pending register, 5-bit count, and FSM with states IDLE, ISSUE, DONE.
REQ-014 IDLE, load=1, Wordline!=0: capture Wordline into pending, clear count, go to ISSUE next edge.
REQ-015 IDLE, load=1, Wordline==0: pending stays 0, count cleared, go to DONE (done pulses next cycle, no valid).
REQ-016 load SHALL be ignored in ISSUE and DONE; pending unaffected by Wordline outside IDLE capture.
REQ-017 ISSUE: valid=1; RegId = index of lowest-numbered set bit of pending (bit 0 highest priority).
REQ-018 valid, RegId, last SHALL be combinational from registered state/pending only (no dependence on ready or load).
REQ-019 ISSUE, ready=1: clear pending[RegId], count increments by 1 at that edge.
REQ-020 ISSUE, ready=0: pending, RegId, count held stable; valid stays 1 (no retraction).
REQ-021 last=1 exactly when valid=1 and pending has one bit set.
REQ-022 ISSUE, ready=1, last=1: transition to DONE.
REQ-023 DONE: done=1, valid=0, for exactly one cycle; unconditional return to IDLE.
REQ-024 Outside ISSUE: valid=0, last=0, RegId=0.
REQ-025 count SHALL hold its final value in IDLE until next accepted load.
REQ-026 Latency: load sampled at edge N -> valid high in cycle after edge N; with ready held 1, k set bits complete in k cycles, done in cycle k+1 after capture.
REQ-027 Wordline=16'hFFFF SHALL yield RegId 0..15 in order and count=16 (no wrap of count).
REQ-028 busy = (state != IDLE).

Reset
REQ-029 rst=1 SHALL immediately (asynchronously) force state IDLE, pending=0, count=0.
REQ-030 Reset outputs: busy=0, valid=0, RegId=0, last=0, done=0, count=0.
REQ-031 Reset asserted mid-ISSUE SHALL abort the sequence; no done pulse follows.
REQ-032 After rst deassert, first load honoured on first rising edge with rst=0.

Verification
REQ-033 Load 16'h0005, ready=1 -> RegId 0 (last=0), then RegId 2 (last=1), then done pulse, count=2.
REQ-034 Load 16'h8000, ready=0 for 3 cycles then 1 -> valid held with RegId 15, last=1 throughout; done after acceptance, count=1.
REQ-035 Load 16'h0000 -> no valid; done one cycle after capture; count=0; busy high only that cycle.
REQ-036 Load 16'hFFFF, ready=1 -> RegId 0..15 consecutive cycles, last only on 15, count=16.
REQ-037 Load 16'h00F0, assert load with 16'h0001 during ISSUE -> second load ignored, sequence 4,5,6,7.
REQ-038 Load 16'h0C00, assert rst after first acceptance -> outputs immediately zero, no done; next load 16'h0002 yields RegId 1, count=1.
